// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: opcode constants, forward-select encodings and hazard predicates.
package hazard_ctrl_pkg;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;
  function automatic logic writes_rd(input logic [4:0] op, input logic [4:0] rd);
    return op != OPC_STORE && op != OPC_BRANCH && rd != 5'd0;
  endfunction
  function automatic logic reads_rs1(input logic [4:0] op);
    return op != OPC_LUI && op != OPC_AUIPC && op != OPC_JAL;
  endfunction
  function automatic logic reads_rs2(input logic [4:0] op);
    return op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;
  endfunction
  // A load still in M has no data yet, so it never sources M forwarding.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] m_op,
                                         input logic [4:0] m_rd, input logic [4:0] w_op,
                                         input logic [4:0] w_rd);
    return rs == 5'd0 ? FWD_RF :
           (writes_rd(m_op, m_rd) && m_op != OPC_LOAD && m_rd == rs) ? FWD_M :
           (writes_rd(w_op, w_rd) && w_rd == rs) ? FWD_W : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_pipe.sv
// hazard_pipe: tracks op/rd of the instructions in M and W; never frozen by stall.
module hazard_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] E_op,
  input  logic [4:0] E_rd,
  output logic [4:0] M_op,
  output logic [4:0] M_rd,
  output logic [4:0] W_op,
  output logic [4:0] W_rd
);
  logic [4:0] m_op_q, m_rd_q, w_op_q, w_rd_q;
  logic [4:0] m_op_d, m_rd_d, w_op_d, w_rd_d;
  always_comb begin
    m_op_d = E_op;
    m_rd_d = E_rd;
    w_op_d = m_op_q;
    w_rd_d = m_rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_op_q <= '0;
      m_rd_q <= '0;
      w_op_q <= '0;
      w_rd_q <= '0;
    end else begin
      m_op_q <= m_op_d;
      m_rd_q <= m_rd_d;
      w_op_q <= w_op_d;
      w_rd_q <= w_rd_d;
    end
  end
  assign M_op = m_op_q;
  assign M_rd = m_rd_q;
  assign W_op = w_op_q;
  assign W_rd = w_rd_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush, E operand forwarding and decode W bypass.
// Define HAZARD_PERF_EN to add 32-bit stall_cnt/flush_cnt performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  input  logic [4:0]  D_op,
  input  logic [4:0]  D_rs1,
  input  logic [4:0]  D_rs2,
  input  logic [4:0]  E_op,
  input  logic [4:0]  E_rd,
  input  logic [4:0]  E_rs1,
  input  logic [4:0]  E_rs2,
  input  logic        jb,
  output logic        stall,
  output logic        flush,
  output logic [1:0]  E_rs1_fwd,
  output logic [1:0]  E_rs2_fwd,
  output logic        D_rs1_wbyp,
  output logic        D_rs2_wbyp
);
  logic [4:0] m_op, m_rd, w_op, w_rd;
  logic       load_use;
  hazard_pipe u_pipe (
    .clk  (clk),
    .rst  (rst),
    .E_op (E_op),
    .E_rd (E_rd),
    .M_op (m_op),
    .M_rd (m_rd),
    .W_op (w_op),
    .W_rd (w_rd)
  );
  always_comb begin
    load_use = E_op == OPC_LOAD && E_rd != 5'd0 &&
               ((reads_rs1(D_op) && D_rs1 == E_rd) || (reads_rs2(D_op) && D_rs2 == E_rd));
    stall = load_use && !jb;
    flush = jb;
    E_rs1_fwd = fwd_sel(E_rs1, m_op, m_rd, w_op, w_rd);
    E_rs2_fwd = fwd_sel(E_rs2, m_op, m_rd, w_op, w_rd);
    D_rs1_wbyp = writes_rd(w_op, w_rd) && w_rd == D_rs1;
    D_rs2_wbyp = writes_rd(w_op, w_rd) && w_rd == D_rs2;
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    flush_cnt_d = flush_cnt_q + {31'd0, flush};
  end
  always_ff @(posedge clk) begin
    stall_cnt_q <= rst ? '0 : stall_cnt_d;
    flush_cnt_q <= rst ? '0 : flush_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with a queued scoreboard checked by a monitor.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] D_op = '0, D_rs1 = '0, D_rs2 = '0;
  logic [4:0] E_op = '0, E_rd = '0, E_rs1 = '0, E_rs2 = '0;
  logic jb = 1'b0;
  logic stall, flush, D_rs1_wbyp, D_rs2_wbyp;
  logic [1:0] E_rs1_fwd, E_rs2_fwd;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  hazard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
`ifdef HAZARD_PERF_EN
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
`endif
    .D_op       (D_op),
    .D_rs1      (D_rs1),
    .D_rs2      (D_rs2),
    .E_op       (E_op),
    .E_rd       (E_rd),
    .E_rs1      (E_rs1),
    .E_rs2      (E_rs2),
    .jb         (jb),
    .stall      (stall),
    .flush      (flush),
    .E_rs1_fwd  (E_rs1_fwd),
    .E_rs2_fwd  (E_rs2_fwd),
    .D_rs1_wbyp (D_rs1_wbyp),
    .D_rs2_wbyp (D_rs2_wbyp)
  );
  always #5 clk = ~clk;
  localparam logic [4:0] LD = 5'b00000, ST = 5'b01000, OP = 5'b01100, OPI = 5'b00100;
  localparam logic [4:0] LUI = 5'b01101, JAL = 5'b11011;
  typedef struct {
    string      nm;
    logic [7:0] ex;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  // Expected packing: {stall, flush, E_rs1_fwd, E_rs2_fwd, D_rs1_wbyp, D_rs2_wbyp}
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [7:0] got;
      e = sb.pop_front();
      got = {stall, flush, E_rs1_fwd, E_rs2_fwd, D_rs1_wbyp, D_rs2_wbyp};
      n_vec++;
      if (got !== e.ex) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b (stall,flush,fwd1,fwd2,wb1,wb2)", e.nm, got, e.ex);
      end
    end
  end
  task automatic apply(input string nm, input logic r, input logic [4:0] dop, input logic [4:0] drs1,
                       input logic [4:0] drs2, input logic [4:0] eop, input logic [4:0] erd,
                       input logic [4:0] ers1, input logic [4:0] ers2, input logic j,
                       input logic [7:0] ex);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    D_op = dop; D_rs1 = drs1; D_rs2 = drs2;
    E_op = eop; E_rd = erd; E_rs1 = ers1; E_rs2 = ers2;
    jb = j;
    e.nm = nm;
    e.ex = ex;
    sb.push_back(e);
  endtask
  initial begin
    apply("reset",        1, OPI, 0, 0, LD, 0, 0, 0, 0, 8'b0_0_00_00_0_0);
    apply("load_use",     0, OP,  5, 0, LD, 5, 0, 0, 0, 8'b1_0_00_00_0_0);
    apply("stall_clear",  0, OP,  5, 0, LD, 0, 0, 0, 0, 8'b0_0_00_00_0_0);
    apply("load_fwd_w",   0, OPI, 0, 0, OP, 3, 5, 0, 0, 8'b0_0_10_00_0_0);
    apply("fwd_m",        0, OPI, 0, 0, OP, 0, 0, 3, 0, 8'b0_0_00_01_0_0);
    apply("fwd_w_wbyp",   0, OP,  3, 3, OP, 7, 0, 3, 0, 8'b0_0_00_10_1_1);
    apply("fwd_m_rd7",    0, OPI, 0, 0, OP, 7, 7, 0, 0, 8'b0_0_01_00_0_0);
    apply("m_over_w",     0, OP,  7, 0, OP, 0, 7, 7, 0, 8'b0_0_01_01_1_0);
    apply("rs_zero",      0, OPI, 0, 0, LD, 0, 0, 7, 0, 8'b0_0_00_10_0_0);
    apply("jb_flush",     0, OP,  5, 0, LD, 5, 0, 0, 1, 8'b0_1_00_00_0_0);
    apply("lui_nostall",  0, LUI, 5, 0, LD, 5, 0, 0, 0, 8'b0_0_00_00_0_0);
    apply("store_rs2",    0, ST,  0, 5, LD, 5, 0, 0, 0, 8'b1_0_00_00_0_1);
    apply("load_in_m",    0, OPI, 0, 0, OP, 0, 5, 0, 0, 8'b0_0_10_00_0_0);
    apply("jal_nostall",  0, JAL, 9, 0, LD, 9, 0, 0, 0, 8'b0_0_00_00_0_0);
    apply("store_nowr",   0, OPI, 9, 0, ST, 9, 0, 0, 0, 8'b0_0_00_00_0_0);
    apply("rst_w9",       1, OPI, 9, 0, OP, 0, 9, 0, 0, 8'b0_0_10_00_1_0);
    apply("post_rst",     0, OPI, 9, 0, OP, 0, 9, 0, 0, 8'b0_0_00_00_0_0);
    apply("rst_in_stall", 1, OP,  5, 0, LD, 5, 0, 0, 0, 8'b1_0_00_00_0_0);
    apply("after_rst2",   0, OP,  5, 0, LD, 0, 5, 0, 0, 8'b0_0_00_00_0_0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock, all state updates on rising edge; rst  input  1  synchronous active-high reset.
REQ-002 SHALL have D_op  input  5  decode-stage opcode (inst[6:2]).
REQ-003 SHALL have D_rs1, D_rs2  input  5 each  decode-stage source registers.
REQ-004 SHALL have E_op, E_rd, E_rs1, E_rs2  input  5 each  execute-stage control fields, fed by the D->E control register outputs.
REQ-005 SHALL have jb  input  1  branch/jump taken, resolved in E.
REQ-006 SHALL have stall  output  1  hold PC and F/D register, bubble E.
REQ-007 SHALL have flush  output  1  squash D and E.
REQ-008 SHALL have E_rs1_fwd, E_rs2_fwd  output  2 each  operand source: 00 regfile, 01 M result, 10 W result.
REQ-009 SHALL have D_rs1_wbyp, D_rs2_wbyp  output  1 each  decode read takes W write data.

Function
REQ-010 SHALL keep internal M_op/M_rd and W_op/W_rd registers: M <= E fields every cycle, W <= M every cycle; stall never freezes M/W.
REQ-011 "writes rd" SHALL mean op not STORE (01000) and not BRANCH (11000) and rd != 0; a bubble (op 0, rd 0) never writes.
REQ-012 "reads rs1" SHALL mean D_op not LUI (01101), AUIPC (00101) or JAL (11011); "reads rs2" SHALL mean D_op in {OP 01100, STORE, BRANCH}.
REQ-013 stall SHALL be 1, combinationally, when E_op == LOAD (00000), E_rd != 0, and D reads a source equal to E_rd.
REQ-014 flush SHALL equal jb; when jb = 1, stall SHALL be 0 (flush wins).
REQ-015 E_rsX_fwd SHALL be 01 when M writes rd, M_op != LOAD and M_rd == E_rsX; otherwise 10 when W writes rd and W_rd == E_rsX; otherwise 00.
REQ-016 M-over-W priority SHALL hold when both match; E_rsX == 0 SHALL always give 00.
REQ-017 D_rsX_wbyp SHALL be 1 when W writes rd and W_rd == D_rsX != 0.
REQ-018 Load in M matching E_rsX SHALL give 00 (cannot occur given REQ-013; no stall is generated for it).
REQ-019 All outputs SHALL be pure functions of inputs and M/W state; no added latency.

Reset
REQ-020 On rst SHALL clear M_op, M_rd, W_op, W_rd to 0 at the next edge; after reset stall = 0, fwd = 00, wbyp = 0 given bubble inputs.
REQ-021 rst SHALL override in-flight state in any cycle, including during stall or jb.

Configuration
REQ-022 With HAZARD_PERF_EN defined SHALL add outputs stall_cnt and flush_cnt (32 bits each), incrementing on each cycle with stall = 1 or flush = 1 respectively, wrapping at 2^32, cleared by rst.
REQ-023 Without HAZARD_PERF_EN those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-024 Opcode constants (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM) and forward-select encodings SHALL reside in the shared CPU package.
REQ-025 The M/W tracking registers SHALL be one sub-module, hazard_pipe, instantiated once.

Verification
REQ-026 E: LOAD rd=5; D: OP rs1=5 -> stall=1; next cycle with E bubble -> stall=0, and one cycle later consumer in E gives E_rs1_fwd=10.
REQ-027 E: OP rd=3, next cycle E_rs2=3 (E_op OP) -> E_rs2_fwd=01; one cycle later, if still E_rs2=3 -> 10.
REQ-028 M and W both rd=7, E_rs1=7 -> E_rs1_fwd=01; E_rs1=0 with M_rd=0 bubble -> 00.
REQ-029 LOAD rd=5 in E, D rs1=5, jb=1 -> flush=1, stall=0.
REQ-030 D: LUI, D_rs1=5, E LOAD rd=5 -> stall=0; D STORE rs2=5 -> stall=1.
REQ-031 rst asserted with W_rd=9 -> next cycle D_rs1=9 gives wbyp=0; with HAZARD_PERF_EN, counters read 0.
